channel_sequencer: RTL
======================

CHANNEL_SEQUENCER -- requirements
Module: channel_sequencer

Interface
REQ-001 Parameter NUM_IN_CH, default 6, number of input channels per output channel (legal range 1..31).
REQ-002 Parameter NUM_OUT_CH, default 16, number of output channels (legal range 1..31).
REQ-003 Parameter ADDR_W, default 10, width of the weight base address.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock shared with the layer controller.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 c_load  input  1  one-cycle strobe: controller in CHANNEL_LOAD.
REQ-008 cin  input  1  one-cycle strobe: controller in COUNT_IN.
REQ-009 cout  input  1  one-cycle strobe: controller in COUNT_OUT.
REQ-010 in_ch_idx  output  5  input channel selected for the current CONV pass.
REQ-011 out_ch_idx  output  5  output channel currently being produced.
REQ-012 cin_done  output  1  level: all NUM_IN_CH input channels of the current output channel have been started.
REQ-013 cout_done  output  1  level: current output channel is the last one.
REQ-014 is_single_input_channel  output  1  constant, 1 iff NUM_IN_CH == 1.
REQ-015 w_base_addr  output  ADDR_W  weight base address = out_ch_idx*NUM_IN_CH + in_ch_idx.
REQ-016 acc_clear  output  1  one-cycle pulse: clear partial-sum accumulator.
REQ-017 out_wr  output  1  one-cycle pulse: commit accumulated output channel out_wr_ch to the feature buffer.
REQ-018 out_wr_ch  output  5  output channel index accompanying out_wr.
REQ-019 seq_done  output  1  sticky: all output channels committed.

Function
REQ-020 Internal register in_cnt (5 bits) SHALL count input channels started for the current output channel.
REQ-021 cin_done SHALL be combinational: (in_cnt == NUM_IN_CH), valid in the same cycle as the cin strobe.
REQ-022 cout_done SHALL be combinational: (out_ch_idx == NUM_OUT_CH-1), valid in the same cycle as the cout strobe.
REQ-023 On c_load: in_cnt <= 0, in_ch_idx <= 0, acc_clear <= 1 for exactly the next cycle; out_ch_idx unchanged.
REQ-024 On cin with cin_done=0: in_ch_idx <= in_cnt, in_cnt <= in_cnt+1.
REQ-025 On cin with cin_done=1: in_cnt and in_ch_idx SHALL hold.
REQ-026 When NUM_IN_CH == 1, in_ch_idx SHALL remain 0 and cin strobes SHALL not occur; in_cnt is unused.
REQ-027 On cout: out_wr <= 1 and out_wr_ch <= out_ch_idx for exactly the next cycle.
REQ-028 On cout with cout_done=0: out_ch_idx <= out_ch_idx+1.
REQ-029 On cout with cout_done=1: out_ch_idx SHALL hold, seq_done <= 1 and stays 1 until reset.
REQ-030 w_base_addr SHALL be registered, updated one cycle after any change of in_ch_idx or out_ch_idx (latency 1), truncated to ADDR_W bits.
REQ-031 Simultaneous strobes (illegal): priority c_load > cin > cout; lower-priority strobes in that cycle SHALL be ignored.
REQ-032 After seq_done=1, all strobes SHALL be ignored except that cout still produces no further out_wr.
REQ-033 No counter SHALL wrap: in_cnt saturates at NUM_IN_CH, out_ch_idx saturates at NUM_OUT_CH-1.

Reset
REQ-034 rst=1 SHALL asynchronously force in_cnt, in_ch_idx, out_ch_idx, out_wr_ch, w_base_addr = 0 and acc_clear, out_wr, seq_done = 0.
REQ-035 rst asserted mid-sequence SHALL abandon the sequence; after release the block restarts at output channel 0, input channel 0.
REQ-036 is_single_input_channel SHALL be its constant value during and after reset.

Verification
REQ-037 Defaults; c_load, then 7x (cin, CONV delay) -> cin_done=0 on cin #1..#6 with in_ch_idx 0..5, cin_done=1 on cin #7, in_ch_idx holds 5.
REQ-038 Defaults; full layer (16x: c_load, 7 cin, cout) -> out_wr pulses with out_wr_ch 0..15, cout_done=1 only at 16th cout, seq_done=1 after it.
REQ-039 Defaults; out_ch_idx=3, in_ch_idx=4 -> w_base_addr=22 one cycle after update.
REQ-040 NUM_IN_CH=1, NUM_OUT_CH=6; c_load/cout only -> is_single_input_channel=1, in_ch_idx=0, out_wr_ch 0..5, seq_done after 6th cout.
REQ-041 Defaults; c_load and cin in same cycle -> in_cnt=0, acc_clear pulse, in_ch_idx=0, no increment.
REQ-042 Defaults; rst pulse at out_ch_idx=9, in_cnt=3 -> all outputs 0 immediately; subsequent c_load/cin sequence starts at channel 0.

Source files
------------

// File: rtl/channel_sequencer.sv
// Channel bookkeeping for one CONV layer: tracks which input/output channel is
// active, derives the weight base address and emits accumulator clear/commit strobes.
module channel_sequencer #(
    parameter int unsigned NUM_IN_CH  = 6,
    parameter int unsigned NUM_OUT_CH = 16,
    parameter int unsigned ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_load,
    input  logic              cin,
    input  logic              cout,
    output logic [4:0]        in_ch_idx,
    output logic [4:0]        out_ch_idx,
    output logic              cin_done,
    output logic              cout_done,
    output logic              is_single_input_channel,
    output logic [ADDR_W-1:0] w_base_addr,
    output logic              acc_clear,
    output logic              out_wr,
    output logic [4:0]        out_wr_ch,
    output logic              seq_done
);

    localparam logic [4:0]  IN_LAST  = 5'(NUM_IN_CH);
    localparam logic [4:0]  OUT_LAST = 5'(NUM_OUT_CH - 1);
    localparam logic        MULTI_IN = (NUM_IN_CH > 1);
    // 31*31+31 needs 10 bits; keep a margin and never go narrower than the output
    localparam int unsigned FULL_W   = (ADDR_W > 11) ? ADDR_W : 11;
    localparam logic [FULL_W-1:0] IN_MULT = FULL_W'(NUM_IN_CH);

    logic [4:0]        in_cnt;
    logic              load_go;
    logic              cin_go;
    logic              cout_go;
    logic [FULL_W-1:0] addr_full;

    assign is_single_input_channel = MULTI_IN ? 1'b0 : 1'b1;
    assign cin_done  = (in_cnt == IN_LAST);
    assign cout_done = (out_ch_idx == OUT_LAST);

    // Strobe priority c_load > cin > cout; everything is frozen once the layer is done.
    assign load_go = c_load & ~seq_done;
    assign cin_go  = cin & ~c_load & ~seq_done & ~cin_done & MULTI_IN;
    assign cout_go = cout & ~c_load & ~cin & ~seq_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_cnt    <= '0;
            in_ch_idx <= '0;
        end else if (load_go) begin
            in_cnt    <= '0;
            in_ch_idx <= '0;
        end else if (cin_go) begin
            in_ch_idx <= in_cnt;
            in_cnt    <= in_cnt + 5'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_clear <= 1'b0;
        end else begin
            acc_clear <= load_go;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_ch_idx <= '0;
            out_wr     <= 1'b0;
            out_wr_ch  <= '0;
            seq_done   <= 1'b0;
        end else begin
            out_wr <= cout_go;
            if (cout_go) begin
                out_wr_ch <= out_ch_idx;
                if (cout_done) begin
                    seq_done <= 1'b1;
                end else begin
                    out_ch_idx <= out_ch_idx + 5'd1;
                end
            end
        end
    end

    assign addr_full = FULL_W'(out_ch_idx) * IN_MULT + FULL_W'(in_ch_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_base_addr <= '0;
        end else begin
            w_base_addr <= addr_full[ADDR_W-1:0];
        end
    end

endmodule
